reorder_buffer: RTL and testbench



---
 rtl/reorder_buffer_pkg.sv | 27 ++
 rtl/reorder_buffer.sv | 144 ++++++++++++++
 tb/tb_reorder_buffer.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/reorder_buffer_pkg.sv
// Shared types for the reorder buffer and the commit stage around it.
//   MemoryWord    : one 32-bit data word
//   control_bits  : per-instruction control flags carried through retirement
//   rob_entry     : one in-flight instruction held by the reorder buffer
//   ROB_SIZE_DEFAULT : default number of reorder buffer entries
package reorder_buffer_pkg;

  localparam int ROB_SIZE_DEFAULT = 16;

  typedef logic [31:0] MemoryWord;

  typedef struct packed {
    logic regwr;
    logic flush;
    logic memwr;
    logic memrd;
  } control_bits;

  typedef struct packed {
    MemoryWord   pc;
    logic [4:0]  dest;
    MemoryWord   value;
    logic        ready;
    control_bits ctrl_bits;
  } rob_entry;

endpackage

// File: rtl/reorder_buffer.sv
// Circular reorder buffer between dispatch and architectural retirement.
// Dispatch allocates entries at the tail, the commit stage reads and rewrites
// entries by tag, and ready entries retire in program order from the head.
// Retiring an entry flagged for flush empties the buffer and pulses flush.
// Ports:
//   clk, reset                synchronous active-high reset
//   alloc_valid, alloc_entry  dispatch request and initial entry contents
//   alloc_tag                 tag granted to a request (0 when full)
//   full, empty, count        occupancy, combinational from registered count
//   rd_tag, rd_entry          combinational lookup for the commit stage
//   wb_tag, wb_entry          updated entry returned by the commit stage
//   retire_*                  registered retirement record, one cycle per event
//   flush                     registered one-cycle pulse after a flush retire
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int ROB_SIZE = ROB_SIZE_DEFAULT
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          alloc_valid,
  input  rob_entry                      alloc_entry,
  output logic [31:0]                   alloc_tag,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(ROB_SIZE+1)-1:0] count,
  input  logic [31:0]                   rd_tag,
  output rob_entry                      rd_entry,
  input  logic [31:0]                   wb_tag,
  input  rob_entry                      wb_entry,
  output logic                          retire_valid,
  output logic [31:0]                   retire_tag,
  output logic [4:0]                    retire_dest,
  output MemoryWord                     retire_value,
  output logic                          retire_regwr,
  output logic                          flush
);

  localparam int IDX_W = $clog2(ROB_SIZE);
  localparam int CNT_W = $clog2(ROB_SIZE+1);

  rob_entry             slots [ROB_SIZE];
  logic [ROB_SIZE-1:0]  valid;
  logic [IDX_W-1:0]     head;
  logic [IDX_W-1:0]     tail;
  logic [CNT_W-1:0]     count_q;

  logic                 do_alloc;
  logic                 do_retire;
  logic                 do_flush;
  logic                 wb_hit;
  logic [IDX_W-1:0]     wb_idx;
  logic [IDX_W-1:0]     rd_idx;
  rob_entry             alloc_slot;
  rob_entry             head_entry;

  // Occupancy, grants and the commit-stage lookup all come from registered
  // state only, so same-cycle requests never see their own effect.
  always_comb begin
    count      = count_q;
    full       = (count_q == CNT_W'(ROB_SIZE));
    empty      = (count_q == '0);
    alloc_tag  = full ? 32'd0 : 32'(tail) + 32'd1;

    head_entry = slots[head];
    do_alloc   = alloc_valid && !full;
    do_retire  = valid[head] && head_entry.ready;
    do_flush   = do_retire && head_entry.ctrl_bits.flush;

    // Tags are index+1, so tag 0 and anything past ROB_SIZE never hit a slot.
    wb_idx     = IDX_W'(wb_tag - 32'd1);
    wb_hit     = (wb_tag != 32'd0) && (wb_tag <= 32'(ROB_SIZE)) && valid[wb_idx];

    rd_idx     = IDX_W'(rd_tag - 32'd1);
    rd_entry   = '0;
    if ((rd_tag != 32'd0) && (rd_tag <= 32'(ROB_SIZE)) && valid[rd_idx]) begin
      rd_entry = slots[rd_idx];
    end

    // A freshly dispatched entry always starts not-ready with no result.
    alloc_slot       = alloc_entry;
    alloc_slot.ready = 1'b0;
    alloc_slot.value = '0;
  end

  // Slot storage, pointers and the retirement record. A flushing retire wins
  // over any allocate or writeback arriving in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid        <= '0;
      head         <= '0;
      tail         <= '0;
      count_q      <= '0;
      retire_valid <= 1'b0;
      retire_tag   <= '0;
      retire_dest  <= '0;
      retire_value <= '0;
      retire_regwr <= 1'b0;
      flush        <= 1'b0;
    end else begin
      retire_valid <= do_retire;
      flush        <= do_flush;
      if (do_retire) begin
        retire_tag   <= 32'(head) + 32'd1;
        retire_dest  <= head_entry.dest;
        retire_value <= head_entry.value;
        retire_regwr <= head_entry.ctrl_bits.regwr;
      end else begin
        retire_tag   <= '0;
        retire_dest  <= '0;
        retire_value <= '0;
        retire_regwr <= 1'b0;
      end

      if (do_flush) begin
        valid   <= '0;
        head    <= '0;
        tail    <= '0;
        count_q <= '0;
      end else begin
        if (wb_hit) begin
          slots[wb_idx] <= wb_entry;
        end
        // The tail slot is never valid when an allocate is granted, so it
        // cannot collide with a writeback or with the retiring head.
        if (do_alloc) begin
          slots[tail] <= alloc_slot;
          valid[tail] <= 1'b1;
          tail        <= tail + IDX_W'(1);
        end
        if (do_retire) begin
          valid[head] <= 1'b0;
          head        <= head + IDX_W'(1);
        end
        case ({do_alloc, do_retire})
          2'b10:   count_q <= count_q + CNT_W'(1);
          2'b01:   count_q <= count_q - CNT_W'(1);
          default: count_q <= count_q;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed self-checking bench for reorder_buffer (ROB_SIZE = 16).
// Walks through reset, allocation, out-of-order writeback, fill and wrap,
// invalid writebacks, mispredict flush and reset during operation.
module tb_reorder_buffer;
  import reorder_buffer_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        alloc_valid;
  rob_entry    alloc_entry;
  logic [31:0] alloc_tag;
  logic        full;
  logic        empty;
  logic [4:0]  count;
  logic [31:0] rd_tag;
  rob_entry    rd_entry;
  logic [31:0] wb_tag;
  rob_entry    wb_entry;
  logic        retire_valid;
  logic [31:0] retire_tag;
  logic [4:0]  retire_dest;
  MemoryWord   retire_value;
  logic        retire_regwr;
  logic        flush;

  int checks = 0;
  int errors = 0;

  reorder_buffer #(.ROB_SIZE(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .alloc_valid  (alloc_valid),
    .alloc_entry  (alloc_entry),
    .alloc_tag    (alloc_tag),
    .full         (full),
    .empty        (empty),
    .count        (count),
    .rd_tag       (rd_tag),
    .rd_entry     (rd_entry),
    .wb_tag       (wb_tag),
    .wb_entry     (wb_entry),
    .retire_valid (retire_valid),
    .retire_tag   (retire_tag),
    .retire_dest  (retire_dest),
    .retire_value (retire_value),
    .retire_regwr (retire_regwr),
    .flush        (flush)
  );

  always #5 clk = ~clk;

  // Builds an entry with a recognisable pc derived from its destination.
  function automatic rob_entry mk(input logic [4:0] dest, input logic [31:0] value,
                                  input logic ready, input logic regwr, input logic fl);
    rob_entry e;
    e                 = '0;
    e.pc              = 32'h1000 + 32'(dest);
    e.dest            = dest;
    e.value           = value;
    e.ready           = ready;
    e.ctrl_bits.regwr = regwr;
    e.ctrl_bits.flush = fl;
    return e;
  endfunction

  task automatic applyStimulus(input logic av, input rob_entry ae,
                               input logic [31:0] wt, input rob_entry we);
    alloc_valid = av;
    alloc_entry = ae;
    wb_tag      = wt;
    wb_entry    = we;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkRead(input string tag, input logic [31:0] t, input rob_entry exp);
    rd_tag = t;
    #1;
    checkOutput(tag, 80'(rd_entry), 80'(exp));
  endtask

  initial begin
    rob_entry none;
    none = '0;
    reset = 1'b1;
    rd_tag = '0;
    applyStimulus(1'b0, none, 32'd0, none);
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    checkOutput("reset_count", 80'(count), 80'd0);
    checkOutput("reset_empty", 80'(empty), 80'd1);
    checkOutput("reset_full", 80'(full), 80'd0);
    checkOutput("reset_alloc_tag", 80'(alloc_tag), 80'd1);
    checkOutput("reset_retire_valid", 80'(retire_valid), 80'd0);
    checkOutput("reset_flush", 80'(flush), 80'd0);
    checkRead("reset_rd_tag1", 32'd1, none);

    // Three allocates; garbage ready/value must be cleared on entry
    for (int i = 1; i <= 3; i++) begin
      applyStimulus(1'b1, mk(5'(i), 32'hFF, 1'b1, 1'b1, 1'b0), 32'd0, none);
      checkOutput("alloc_tag_seq", 80'(alloc_tag), 80'(i));
      tick();
    end
    applyStimulus(1'b0, none, 32'd0, none);
    checkOutput("alloc3_count", 80'(count), 80'd3);
    checkOutput("alloc3_empty", 80'(empty), 80'd0);
    checkRead("alloc3_rd_tag2", 32'd2, mk(5'd2, 32'd0, 1'b0, 1'b1, 1'b0));
    tick();
    checkOutput("alloc3_no_retire", 80'(retire_valid), 80'd0);

    // Out-of-order writeback 3, 1, 2; retirement in order 1, 2, 3
    applyStimulus(1'b0, none, 32'd3, mk(5'd3, 32'h30, 1'b1, 1'b1, 1'b0));
    tick();
    applyStimulus(1'b0, none, 32'd1, mk(5'd1, 32'h10, 1'b1, 1'b1, 1'b0));
    tick();
    checkOutput("ooo_no_early_retire", 80'(retire_valid), 80'd0);
    applyStimulus(1'b0, none, 32'd2, mk(5'd2, 32'h20, 1'b1, 1'b1, 1'b0));
    tick();
    checkOutput("ooo_rv1", 80'(retire_valid), 80'd1);
    checkOutput("ooo_tag1", 80'(retire_tag), 80'd1);
    checkOutput("ooo_val1", 80'(retire_value), 80'h10);
    checkOutput("ooo_dest1", 80'(retire_dest), 80'd1);
    checkOutput("ooo_regwr1", 80'(retire_regwr), 80'd1);
    applyStimulus(1'b0, none, 32'd0, none);
    tick();
    checkOutput("ooo_tag2", 80'(retire_tag), 80'd2);
    checkOutput("ooo_val2", 80'(retire_value), 80'h20);
    tick();
    checkOutput("ooo_tag3", 80'(retire_tag), 80'd3);
    checkOutput("ooo_val3", 80'(retire_value), 80'h30);
    tick();
    checkOutput("ooo_rv_drop", 80'(retire_valid), 80'd0);
    checkOutput("ooo_empty", 80'(empty), 80'd1);

    // Fill from a fresh reset
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      applyStimulus(1'b1, mk(5'(i), 32'd0, 1'b0, 1'b0, 1'b0), 32'd0, none);
      checkOutput("fill_alloc_tag", 80'(alloc_tag), 80'(i));
      tick();
    end
    checkOutput("fill_full", 80'(full), 80'd1);
    checkOutput("fill_count", 80'(count), 80'd16);
    checkOutput("fill_alloc_tag0", 80'(alloc_tag), 80'd0);
    applyStimulus(1'b1, mk(5'd31, 32'd0, 1'b0, 1'b0, 1'b0), 32'd0, none);
    tick();
    checkOutput("fill_17th_count", 80'(count), 80'd16);
    checkRead("fill_17th_tag1", 32'd1, mk(5'd1, 32'd0, 1'b0, 1'b0, 1'b0));
    applyStimulus(1'b0, none, 32'd1, mk(5'd1, 32'h11, 1'b1, 1'b0, 1'b0));
    tick();
    applyStimulus(1'b0, none, 32'd0, none);
    tick();
    checkOutput("wrap_retire_tag", 80'(retire_tag), 80'd1);
    checkOutput("wrap_count", 80'(count), 80'd15);
    checkOutput("wrap_alloc_tag", 80'(alloc_tag), 80'd1);
    applyStimulus(1'b1, mk(5'd20, 32'd0, 1'b0, 1'b0, 1'b0), 32'd0, none);
    tick();
    checkOutput("wrap_full_again", 80'(full), 80'd1);
    checkRead("wrap_rd_tag1", 32'd1, mk(5'd20, 32'd0, 1'b0, 1'b0, 1'b0));

    // Allocate alongside a retire while full is refused
    applyStimulus(1'b0, none, 32'd2, mk(5'd2, 32'h22, 1'b1, 1'b0, 1'b0));
    tick();
    applyStimulus(1'b1, mk(5'd21, 32'd0, 1'b0, 1'b0, 1'b0), 32'd0, none);
    tick();
    applyStimulus(1'b0, none, 32'd0, none);
    checkOutput("fullret_retire_tag", 80'(retire_tag), 80'd2);
    checkOutput("fullret_count", 80'(count), 80'd15);
    checkOutput("fullret_alloc_tag", 80'(alloc_tag), 80'd2);

    // Invalid writebacks: tag 0, tag 17, freed slot 2
    applyStimulus(1'b0, none, 32'd0, mk(5'd9, 32'h99, 1'b1, 1'b0, 1'b0));
    tick();
    applyStimulus(1'b0, none, 32'd17, mk(5'd9, 32'h99, 1'b1, 1'b0, 1'b0));
    tick();
    applyStimulus(1'b0, none, 32'd2, mk(5'd9, 32'h99, 1'b1, 1'b0, 1'b0));
    tick();
    applyStimulus(1'b0, none, 32'd0, none);
    checkRead("badwb_tag16", 32'd16, mk(5'd16, 32'd0, 1'b0, 1'b0, 1'b0));
    checkRead("badwb_tag1", 32'd1, mk(5'd20, 32'd0, 1'b0, 1'b0, 1'b0));
    checkRead("badwb_tag2", 32'd2, none);
    checkOutput("badwb_count", 80'(count), 80'd15);
    checkOutput("badwb_no_retire", 80'(retire_valid), 80'd0);

    // Mispredict flush
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1'b1, mk(5'(i), 32'd0, 1'b0, 1'b1, 1'b0), 32'd0, none);
      tick();
    end
    applyStimulus(1'b0, none, 32'd1, mk(5'd1, 32'h41, 1'b1, 1'b1, 1'b0));
    tick();
    applyStimulus(1'b0, none, 32'd2, mk(5'd2, 32'h42, 1'b1, 1'b1, 1'b1));
    tick();
    checkOutput("flush_retire_tag1", 80'(retire_tag), 80'd1);
    checkOutput("flush_not_yet", 80'(flush), 80'd0);
    applyStimulus(1'b1, mk(5'd7, 32'd0, 1'b0, 1'b0, 1'b0), 32'd3, mk(5'd3, 32'h43, 1'b1, 1'b1, 1'b0));
    tick();
    applyStimulus(1'b0, none, 32'd0, none);
    checkOutput("flush_retire_tag2", 80'(retire_tag), 80'd2);
    checkOutput("flush_retire_val2", 80'(retire_value), 80'h42);
    checkOutput("flush_pulse", 80'(flush), 80'd1);
    checkOutput("flush_count", 80'(count), 80'd0);
    checkOutput("flush_empty", 80'(empty), 80'd1);
    checkRead("flush_rd_tag3", 32'd3, none);
    checkOutput("flush_alloc_tag", 80'(alloc_tag), 80'd1);
    applyStimulus(1'b1, mk(5'd8, 32'd0, 1'b0, 1'b0, 1'b0), 32'd0, none);
    tick();
    applyStimulus(1'b0, none, 32'd0, none);
    checkOutput("flush_pulse_end", 80'(flush), 80'd0);
    checkOutput("flush_rv_end", 80'(retire_valid), 80'd0);
    checkOutput("flush_realloc_count", 80'(count), 80'd1);
    checkRead("flush_realloc_tag1", 32'd1, mk(5'd8, 32'd0, 1'b0, 1'b0, 1'b0));

    // Reset with five entries in flight and a ready head
    for (int i = 2; i <= 5; i++) begin
      applyStimulus(1'b1, mk(5'(i), 32'd0, 1'b0, 1'b1, 1'b0), 32'd0, none);
      tick();
    end
    applyStimulus(1'b0, none, 32'd1, mk(5'd8, 32'h55, 1'b1, 1'b1, 1'b0));
    tick();
    checkOutput("midrst_count5", 80'(count), 80'd5);
    applyStimulus(1'b1, mk(5'd9, 32'd0, 1'b0, 1'b0, 1'b0), 32'd2, mk(5'd2, 32'h66, 1'b1, 1'b1, 1'b0));
    reset = 1'b1;
    tick();
    checkOutput("midrst_rv", 80'(retire_valid), 80'd0);
    checkOutput("midrst_rtag", 80'(retire_tag), 80'd0);
    checkOutput("midrst_rval", 80'(retire_value), 80'd0);
    checkOutput("midrst_count", 80'(count), 80'd0);
    checkOutput("midrst_empty", 80'(empty), 80'd1);
    checkOutput("midrst_alloc_tag", 80'(alloc_tag), 80'd1);
    checkOutput("midrst_flush", 80'(flush), 80'd0);
    reset = 1'b0;
    applyStimulus(1'b0, none, 32'd0, none);
    checkRead("midrst_rd_tag1", 32'd1, none);
    tick();
    checkOutput("midrst_no_late_retire", 80'(retire_valid), 80'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
